// File: rtl/qam16_pkg.sv
// Shared definitions for the QAM16 transmit mapper.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
// Contents: per-axis Gray level codes, slot FSM state encoding, Gray-to-multiplier map.
package qam16_pkg;

   // Per-axis Gray codes: adjacent amplitude levels differ in one bit.
   localparam logic [1:0] LVL_M3 = 2'b00;
   localparam logic [1:0] LVL_M1 = 2'b01;
   localparam logic [1:0] LVL_P1 = 2'b11;
   localparam logic [1:0] LVL_P3 = 2'b10;

   // Slot FSM: the state names the kind of slot currently on di/dq.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_PRE  = 2'd1;
   localparam state_t ST_DATA = 2'd2;

   // Gray code -> signed multiple of the unit amplitude.
   function automatic int gray_mult(input logic [1:0] code);
      int m;
      case (code)
         LVL_M3:  m = -3;
         LVL_M1:  m = -1;
         LVL_P1:  m = 1;
         default: m = 3;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/qam16_level.sv
// Maps one 2-bit Gray code to a signed W-bit amplitude level (+-AMP, +-3*AMP).
// Latency: combinational.
// Backpressure: none; output follows the input code.
// Ports: code (2-bit Gray code in), level (signed W-bit level out).
module qam16_level #(
   parameter int W   = 12,
   parameter int AMP = 256
) (
   input  logic [1:0]          code,
   output logic signed [W-1:0] level
);
   import qam16_pkg::*;

   // Product is a small constant multiple of AMP; truncation to W bits is
   // exact because the top level guarantees 3*AMP fits.
   always_comb level = W'(gray_mult(code) * AMP);

endmodule

// File: rtl/qam16_mapper.sv
// QAM16 symbol mapper: pulls 4 bits per symbol, emits Gray-mapped I/Q levels behind a per-frame preamble.
// Latency: the last bit of a symbol (sampled at cnt=3Q) reaches di/dq Q cycles later on the symbol wrap.
// Backpressure: none; the mapper paces the source through bit_en and never waits on din.
// Ports: clk, rst (sync, active-high), din (serial bit) in; bit_en (bit request), di/dq (signed W-bit I/Q),
//        sym_start (first cycle of each non-idle symbol), in_pre (preamble symbol on di/dq) out.
module qam16_mapper #(
   parameter int SYM_DIV   = 32,
   parameter int PRE_LEN   = 16,
   parameter int FRAME_LEN = 200,
   parameter int W         = 12,
   parameter int AMP       = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din,
   output logic                bit_en,
   output logic signed [W-1:0] di,
   output logic signed [W-1:0] dq,
   output logic                sym_start,
   output logic                in_pre
);
   import qam16_pkg::*;

   localparam int Q    = SYM_DIV / 4;
   localparam int CW   = $clog2(SYM_DIV);
   localparam int MAXL = (PRE_LEN > FRAME_LEN) ? PRE_LEN : FRAME_LEN;
   localparam int IW   = $clog2(MAXL + 1);
   localparam logic signed [W-1:0] PRE_P = W'(3 * AMP);
   localparam logic signed [W-1:0] PRE_N = W'(-3 * AMP);

   if (3 * AMP > 2 ** (W - 1) - 1) begin : g_amp_chk
      $error("qam16_mapper: 3*AMP does not fit in a signed W-bit level");
   end
   if ((SYM_DIV % 4) != 0 || SYM_DIV < 8) begin : g_div_chk
      $error("qam16_mapper: SYM_DIV must be a multiple of 4 and at least 8");
   end
   if (PRE_LEN < 1 || FRAME_LEN < 1) begin : g_len_chk
      $error("qam16_mapper: PRE_LEN and FRAME_LEN must be at least 1");
   end

   logic [CW-1:0]       cnt;
   state_t              state;
   logic [IW-1:0]       idx;
   logic [3:0]          sreg;
   logic                wrap;
   logic                pre_last;
   logic                data_last;
   logic                collect;
   logic signed [W-1:0] lvl_i;
   logic signed [W-1:0] lvl_q;

   assign wrap      = (cnt == CW'(SYM_DIV - 1));
   assign pre_last  = (state == ST_PRE)  && (idx == IW'(PRE_LEN - 1));
   assign data_last = (state == ST_DATA) && (idx == IW'(FRAME_LEN - 1));

   // Bits are gathered one slot ahead: only slots followed by a data slot collect.
   assign collect = pre_last || ((state == ST_DATA) && !data_last);
   assign bit_en  = collect && ((cnt == CW'(0))     || (cnt == CW'(Q)) ||
                                (cnt == CW'(2 * Q)) || (cnt == CW'(3 * Q)));

   qam16_level #(.W(W), .AMP(AMP)) u_lvl_i (.code(sreg[3:2]), .level(lvl_i));
   qam16_level #(.W(W), .AMP(AMP)) u_lvl_q (.code(sreg[1:0]), .level(lvl_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         state     <= ST_IDLE;
         idx       <= '0;
         sreg      <= '0;
         di        <= '0;
         dq        <= '0;
         sym_start <= 1'b0;
         in_pre    <= 1'b0;
      end else begin
         // Every slot after the idle one is non-idle, so each wrap starts a real symbol.
         sym_start <= wrap;
         if (bit_en) sreg <= {sreg[2:0], din};
         if (wrap) begin
            cnt <= '0;
            case (state)
               ST_IDLE: begin
                  state  <= ST_PRE;
                  idx    <= '0;
                  di     <= PRE_P;
                  dq     <= PRE_P;
                  in_pre <= 1'b1;
               end
               ST_PRE: begin
                  if (pre_last) begin
                     state  <= ST_DATA;
                     idx    <= '0;
                     di     <= lvl_i;
                     dq     <= lvl_q;
                     in_pre <= 1'b0;
                  end else begin
                     // Next preamble index is idx+1: odd when idx is even.
                     idx <= idx + 1'b1;
                     di  <= idx[0] ? PRE_P : PRE_N;
                     dq  <= idx[0] ? PRE_P : PRE_N;
                  end
               end
               default: begin
                  if (data_last) begin
                     state  <= ST_PRE;
                     idx    <= '0;
                     di     <= PRE_P;
                     dq     <= PRE_P;
                     in_pre <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                     di  <= lvl_i;
                     dq  <= lvl_q;
                  end
               end
            endcase
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/qam16_mapper.md
# qam16_mapper

Transmit-side QAM16 baseband symbol mapper. It pulls a serial bit stream from the framing logic, groups 4 bits per symbol, and Gray-maps them to signed I/Q amplitude levels ±AMP/±3·AMP. Each frame is preceded by a full-scale preamble, so the receiver's peak-tracking threshold gate converges before data arrives. Its outputs feed the I/Q modulator (NCO multiply) at the 8 MHz system clock.

## Interface
- SYM_DIV, 32: clocks per symbol; multiple of 4, ≥8; Q = SYM_DIV/4 clocks per bit
- PRE_LEN, 16: preamble symbols per frame, ≥1
- FRAME_LEN, 200: data symbols per frame, ≥1
- W, 12: output width
- AMP, 256: unit amplitude; 3·AMP ≤ 2^(W-1)−1 (elaboration-time check)
- clk  in  1  system clock, 8 MHz
- rst  in  1  reset; synchronous and active-high
- din  in  1  serial data bit, sampled at the end of every cycle with bit_en=1
- bit_en  out  1  bit request strobe
- di  out  W  signed I level
- dq  out  W  signed Q level
- sym_start  out  1  one-cycle pulse in the first cycle of each new non-idle symbol
- in_pre  out  1  high while di/dq carry a preamble symbol

## Operation
- Symbol counter cnt runs 0..SYM_DIV−1 and wraps. di/dq/in_pre load on the edge where cnt wraps; sym_start is registered high in the following cycle (cnt=0).
- Slot sequence after reset:
  - Slot 0 is idle, with di=dq=0.
  - Then PRE_LEN preamble slots, then FRAME_LEN data slots.
  - Then back to preamble, repeating indefinitely with no further idle slot.
- FSM states: IDLE → PRE (count PRE_LEN) → DATA (count FRAME_LEN) → PRE.
- Preamble symbol at index k (0-based within the preamble): k even → di=dq=+3·AMP; k odd → di=dq=−3·AMP.
- Bit collection runs during any slot whose successor is a data slot. This is the last preamble slot and every data slot except the last of the frame.
  - In a collecting slot, bit_en=1 exactly in cycles with cnt ∈ {0, Q, 2Q, 3Q}.
  - Sampled bits shift MSB-first: sreg ← {sreg[2:0], din}.
- Data mapping at the load edge: sreg[3:2] → di, sreg[1:0] → dq.
- Per-axis Gray code: 00→−3·AMP, 01→−AMP, 11→+AMP, 10→+3·AMP.
- Arithmetic: levels are constants sign-extended to W bits. No saturation path exists.
- bit_en is never asserted in IDLE, in non-final preamble slots, or in the final data slot.

## Timing
- Reset values: cnt=0, state IDLE, sreg=0, di=dq=0, bit_en=0, sym_start=0, in_pre=0.
- Reset asserted mid-symbol or mid-frame:
  - On the next edge, everything returns to reset values.
  - Partially collected bits are discarded.
  - The sequence restarts with the idle slot.
- Bit-to-output latency: the 4th bit of a symbol is sampled at cnt=3Q. Its symbol appears on di/dq Q clocks later (at the wrap edge).
- The transition from last data slot to preamble, and from last preamble slot to data, is seamless: there are no gap cycles.
- di/dq are held constant for exactly SYM_DIV cycles per slot.
- din is a don't-care whenever bit_en=0.

## Structure
- Shared package qam16_pkg holds:
  - level code constants LVL_M3, LVL_M1, LVL_P1, LVL_P3
  - FSM state typedef (IDLE/PRE/DATA)
  - the Gray map function
- Sub-module qam16_level (2-bit Gray code + AMP → signed W-bit level), instantiated once for I and once for Q.

## Test plan
Parameters for all scenarios: SYM_DIV=8, PRE_LEN=2, FRAME_LEN=3, AMP=256, W=12.
- Reset release → di=dq=0 for cycles 0–7; at cnt wrap di=dq=+768, in_pre=1, sym_start one cycle; next slot di=dq=−768.
- bit_en pattern → pulses at cnt 0, 2, 4, 6 in slot 2 and in data slots 1–2 only; none in slot 0, preamble slot 0, or the final data slot. Exactly 12 pulses per frame.
- din=1,0,0,1 in slot 2 → slot 3 di=+768, dq=−256, in_pre=0. Then din=0,1,1,1 → di=−256, dq=+256.
- All 16 nibble values across frames → each axis yields only {−768, −256, +256, +768}, per the Gray table.
- After 3 data slots → in_pre=1 again with di=dq=+768; no idle slot; sym_start spacing is exactly 8 cycles throughout.
- rst pulsed for one cycle at cnt=5 of a data slot → outputs 0 on the next edge, then a full idle slot and restart; stale sreg bits never appear.
